fir_sched_ctrl: RTL and testbench
=================================

Name: fir_sched_ctrl

Overview:
- Controller in front of the adaptive-coefficient FIR datapath.
- Shares the FIR's single x_n input between two requesters: a coefficient-load stream and a sample stream.
- Buffers a full coefficient set and programs the filter in one uninterrupted burst, since the filter shifts taps every cycle while set_coeffs is high.
- Flushes the delay line at the end of each sample burst and retimes the filter output into a valid-qualified result stream.

Parameters:
TAP_SIZE  6  coefficient width
NBR_OF_TAPS  5  coefficients per set / flush length
X_N_SIZE  8  sample width
Y_N_SIZE  14  filter output width
SETUP_CYCLES  4  post-reset wait for filter self-init
MAX_BURST  16  samples accepted in one RUN burst while a coefficient load is pending
RES_LAT  2  cycles from a fir_tvalid-high cycle to its y_n being valid

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
coef_valid  in  1  coefficient beat offered
coef_ready  out  1  coefficient beat accepted when coef_valid&coef_ready
coef_data  in  TAP_SIZE  signed coefficient
coef_last  in  1  final beat of a set
smp_valid  in  1  sample offered
smp_ready  out  1  sample accepted when smp_valid&smp_ready
smp_data  in  X_N_SIZE  signed sample
fir_x_n  out  X_N_SIZE  to filter x_n
fir_tvalid  out  1  to filter s_axis_fir_tvalid
fir_set_coeffs  out  1  to filter s_set_coeffs
fir_y_n  in  Y_N_SIZE  from filter y_n
res_valid  out  1  result qualifier
res_data  out  Y_N_SIZE  filter result
res_last  out  1  marks last flush result of a burst
cfg_done  out  1  one-cycle pulse when programming completes
coef_err  out  1  sticky: set had more than NBR_OF_TAPS beats

Behaviour:
- Reset (synchronous): state=INIT; counters and shadow regs cleared; delay line cleared.
  - All outputs 0: ready signals, fir_* signals, res_*, cfg_done, coef_err.
  - Reset asserted mid-operation aborts the operation the same way; partial sets are discarded.
- All outputs are registered.
- States: INIT, IDLE, COLLECT, PROGRAM, GAP, RUN, DRAIN.
- INIT:
  - Held for SETUP_CYCLES cycles, then IDLE.
  - Nothing is accepted.
- IDLE:
  - Arbitration: coef_valid → COLLECT; else smp_valid → RUN.
  - Coefficient load wins a tie.
- COLLECT:
  - coef_ready=1. Beat k (0-based) is stored in shadow[k] while k<NBR_OF_TAPS.
  - Beats beyond NBR_OF_TAPS are accepted, discarded, and set coef_err.
  - coef_last accepted → PROGRAM.
  - Entries not written in this set are 0.
  - coef_valid may gap; the state waits.
- PROGRAM:
  - Exactly NBR_OF_TAPS consecutive cycles, fir_set_coeffs=1.
  - fir_x_n = sign-extended shadow[NBR_OF_TAPS-1-c] on cycle c, so shadow[0] is driven last.
  - Then → GAP.
- GAP:
  - One cycle with fir_set_coeffs=0 and fir_x_n=0.
  - cfg_done=1 in this cycle; → IDLE.
- RUN:
  - smp_ready=1; fir_tvalid=1; fir_x_n=smp_data for each accepted beat.
  - Burst counter increments per accepted sample.
  - → DRAIN when either:
    - smp_valid is low (no bubble; that cycle already drives a zero with tvalid=1 and counts as drain cycle 0), or
    - coef_valid is high and the burst count has reached MAX_BURST (starvation guard).
- DRAIN:
  - smp_ready=0, fir_tvalid=1, fir_x_n=0 for NBR_OF_TAPS cycles total, then → IDLE.
  - Requests arriving during DRAIN wait for IDLE.
- Result path:
  - RES_LAT-deep shift register of fir_tvalid, plus a parallel last-flag that is set on the final DRAIN cycle.
  - res_valid = delayed tvalid; res_data = fir_y_n registered when delayed tvalid is high, else 0.
  - res_last = delayed last-flag.
- Widths: coefficients are sign-extended TAP_SIZE→X_N_SIZE; no other arithmetic.
- Burst counter saturates at MAX_BURST.

Test Plan:
- Reset, then hold idle for 10 cycles → all ready signals 0 for 4 cycles; IDLE reached on cycle 5; no fir_* activity.
- Load coefficients 1,2,3,4,5 with last on beat 5 → fir_set_coeffs high for exactly 5 cycles with x_n = 5,4,3,2,1; cfg_done pulses once; coef_err=0.
- Load coefficient −3 with last on beat 1 → program sequence 0,0,0,0,0xFD; a 7-beat set sets coef_err, and it stays set until reset.
- After loading 1,0,0,0,0, send samples 10,−20,30 then drop smp_valid → 8 tvalid cycles (3 samples, 5 zeros); 8 res_valid results RES_LAT later with values 10,−20,30,0,…; res_last on the 8th.
- Run a continuous sample stream and raise coef_valid at sample 3 → 16 samples accepted, 5-cycle DRAIN, then COLLECT; smp_ready stays 0 until programming finishes.
- Assert reset during PROGRAM cycle 2 → next cycle fir_set_coeffs=0 and state=INIT; a later set starts from clean shadow registers.

Source files
------------

// File: rtl/fir_sched_ctrl.sv
// Arbitrates the FIR's shared x_n input between coefficient sets and sample bursts,
// programs a buffered set in one burst, flushes after each burst, retimes y_n into a result stream.
module fir_sched_ctrl #(
    parameter int TAP_SIZE     = 6,
    parameter int NBR_OF_TAPS  = 5,
    parameter int X_N_SIZE     = 8,
    parameter int Y_N_SIZE     = 14,
    parameter int SETUP_CYCLES = 4,
    parameter int MAX_BURST    = 16,
    parameter int RES_LAT      = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                coef_valid,
    output logic                coef_ready,
    input  logic [TAP_SIZE-1:0] coef_data,
    input  logic                coef_last,
    input  logic                smp_valid,
    output logic                smp_ready,
    input  logic [X_N_SIZE-1:0] smp_data,
    output logic [X_N_SIZE-1:0] fir_x_n,
    output logic                fir_tvalid,
    output logic                fir_set_coeffs,
    input  logic [Y_N_SIZE-1:0] fir_y_n,
    output logic                res_valid,
    output logic [Y_N_SIZE-1:0] res_data,
    output logic                res_last,
    output logic                cfg_done,
    output logic                coef_err
);

    localparam int CW    = $clog2(NBR_OF_TAPS + 1);
    localparam int SMAX  = (NBR_OF_TAPS > SETUP_CYCLES) ? NBR_OF_TAPS : SETUP_CYCLES;
    localparam int SW    = $clog2(SMAX + 1);
    localparam int BW    = $clog2(MAX_BURST + 1);
    localparam logic [SW-1:0] TAP_LAST  = SW'(NBR_OF_TAPS - 1);
    localparam logic [SW-1:0] INIT_LAST = SW'(SETUP_CYCLES - 1);
    localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_COLLECT,
        S_PROGRAM,
        S_GAP,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t                state_q, state_d;
    logic [SW-1:0]         step_q, step_d;
    logic [CW-1:0]         beat_q, beat_d;
    logic [BW-1:0]         burst_q, burst_d;
    logic [TAP_SIZE-1:0]   shadow_q [NBR_OF_TAPS];
    logic [TAP_SIZE-1:0]   shadow_d [NBR_OF_TAPS];
    logic                  coef_err_q, coef_err_d;
    logic                  coef_ready_q, coef_ready_d;
    logic                  smp_ready_q, smp_ready_d;
    logic [X_N_SIZE-1:0]   x_n_q, x_n_d;
    logic                  tvalid_q, tvalid_d;
    logic                  set_q, set_d;
    logic                  cfg_done_q, cfg_done_d;
    logic                  flush_last_q, flush_last_d;
    logic [RES_LAT-1:0]    tv_dly_q, tv_dly_d;
    logic [RES_LAT-1:0]    last_dly_q, last_dly_d;
    logic                  res_valid_q, res_valid_d;
    logic [Y_N_SIZE-1:0]   res_data_q, res_data_d;
    logic                  res_last_q, res_last_d;

    // Outputs are registered from next-state decode, so ready is high exactly while in the accepting state.
    always_comb begin
        state_d      = state_q;
        step_d       = step_q;
        beat_d       = beat_q;
        burst_d      = burst_q;
        shadow_d     = shadow_q;
        coef_err_d   = coef_err_q;
        coef_ready_d = 1'b0;
        smp_ready_d  = 1'b0;
        x_n_d        = '0;
        tvalid_d     = 1'b0;
        set_d        = 1'b0;
        cfg_done_d   = 1'b0;
        flush_last_d = 1'b0;

        case (state_q)
            S_INIT: begin
                if (step_q == INIT_LAST) begin
                    state_d = S_IDLE;
                    step_d  = '0;
                end else begin
                    step_d = step_q + SW'(1);
                end
            end
            S_IDLE: begin
                step_d = '0;
                if (coef_valid) begin
                    state_d      = S_COLLECT;
                    beat_d       = '0;
                    shadow_d     = '{default: '0};
                    coef_ready_d = 1'b1;
                end else if (smp_valid) begin
                    state_d     = S_RUN;
                    burst_d     = '0;
                    smp_ready_d = 1'b1;
                end
            end
            S_COLLECT: begin
                coef_ready_d = 1'b1;
                if (coef_valid && coef_ready_q) begin
                    if (beat_q < CW'(NBR_OF_TAPS)) begin
                        for (int k = 0; k < NBR_OF_TAPS; k++) begin
                            if (beat_q == CW'(k)) begin
                                shadow_d[k] = coef_data;
                            end
                        end
                        beat_d = beat_q + CW'(1);
                    end else begin
                        coef_err_d = 1'b1;
                    end
                    if (coef_last) begin
                        state_d      = S_PROGRAM;
                        step_d       = '0;
                        coef_ready_d = 1'b0;
                    end
                end
            end
            S_PROGRAM: begin
                // Highest tap goes first so shadow[0] lands in the filter's first tap.
                set_d = 1'b1;
                for (int k = 0; k < NBR_OF_TAPS; k++) begin
                    if (step_q == SW'(NBR_OF_TAPS - 1 - k)) begin
                        x_n_d = {{(X_N_SIZE - TAP_SIZE){shadow_q[k][TAP_SIZE-1]}}, shadow_q[k]};
                    end
                end
                if (step_q == TAP_LAST) begin
                    state_d = S_GAP;
                    step_d  = '0;
                end else begin
                    step_d = step_q + SW'(1);
                end
            end
            S_GAP: begin
                cfg_done_d = 1'b1;
                state_d    = S_IDLE;
            end
            S_RUN: begin
                tvalid_d = 1'b1;
                if (smp_valid && smp_ready_q) begin
                    x_n_d   = smp_data;
                    burst_d = (burst_q == BURST_MAX) ? burst_q : burst_q + BW'(1);
                    if (coef_valid && burst_d == BURST_MAX) begin
                        state_d = S_DRAIN;
                        step_d  = '0;
                    end else begin
                        smp_ready_d = 1'b1;
                    end
                end else begin
                    // The bubble cycle already pushes a zero, so it is flush cycle 0.
                    state_d = S_DRAIN;
                    step_d  = SW'(1);
                end
            end
            S_DRAIN: begin
                tvalid_d = 1'b1;
                if (step_q == TAP_LAST) begin
                    state_d      = S_IDLE;
                    step_d       = '0;
                    flush_last_d = 1'b1;
                end else begin
                    step_d = step_q + SW'(1);
                end
            end
            default: begin
                state_d = S_INIT;
                step_d  = '0;
            end
        endcase
    end

    always_comb begin
        tv_dly_d      = '0;
        last_dly_d    = '0;
        tv_dly_d[0]   = tvalid_q;
        last_dly_d[0] = flush_last_q;
        for (int i = 1; i < RES_LAT; i++) begin
            tv_dly_d[i]   = tv_dly_q[i-1];
            last_dly_d[i] = last_dly_q[i-1];
        end
        res_valid_d = tv_dly_q[RES_LAT-1];
        res_data_d  = tv_dly_q[RES_LAT-1] ? fir_y_n : '0;
        res_last_d  = last_dly_q[RES_LAT-1];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_INIT;
            step_q       <= '0;
            beat_q       <= '0;
            burst_q      <= '0;
            for (int k = 0; k < NBR_OF_TAPS; k++) begin
                shadow_q[k] <= '0;
            end
            coef_err_q   <= 1'b0;
            coef_ready_q <= 1'b0;
            smp_ready_q  <= 1'b0;
            x_n_q        <= '0;
            tvalid_q     <= 1'b0;
            set_q        <= 1'b0;
            cfg_done_q   <= 1'b0;
            flush_last_q <= 1'b0;
            tv_dly_q     <= '0;
            last_dly_q   <= '0;
            res_valid_q  <= 1'b0;
            res_data_q   <= '0;
            res_last_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            step_q       <= step_d;
            beat_q       <= beat_d;
            burst_q      <= burst_d;
            shadow_q     <= shadow_d;
            coef_err_q   <= coef_err_d;
            coef_ready_q <= coef_ready_d;
            smp_ready_q  <= smp_ready_d;
            x_n_q        <= x_n_d;
            tvalid_q     <= tvalid_d;
            set_q        <= set_d;
            cfg_done_q   <= cfg_done_d;
            flush_last_q <= flush_last_d;
            tv_dly_q     <= tv_dly_d;
            last_dly_q   <= last_dly_d;
            res_valid_q  <= res_valid_d;
            res_data_q   <= res_data_d;
            res_last_q   <= res_last_d;
        end
    end

    assign coef_ready     = coef_ready_q;
    assign smp_ready      = smp_ready_q;
    assign fir_x_n        = x_n_q;
    assign fir_tvalid     = tvalid_q;
    assign fir_set_coeffs = set_q;
    assign cfg_done       = cfg_done_q;
    assign coef_err       = coef_err_q;
    assign res_valid      = res_valid_q;
    assign res_data       = res_data_q;
    assign res_last       = res_last_q;

endmodule

// File: tb/tb_fir_sched_ctrl.sv
// Directed bench for fir_sched_ctrl with a behavioural 5-tap FIR standing in for the filter.
module tb_fir_sched_ctrl;

    logic        clk;
    logic        reset;
    logic        coef_valid;
    logic        coef_ready;
    logic [5:0]  coef_data;
    logic        coef_last;
    logic        smp_valid;
    logic        smp_ready;
    logic [7:0]  smp_data;
    logic [7:0]  fir_x_n;
    logic        fir_tvalid;
    logic        fir_set_coeffs;
    logic [13:0] fir_y_n;
    logic        res_valid;
    logic [13:0] res_data;
    logic        res_last;
    logic        cfg_done;
    logic        coef_err;

    fir_sched_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .coef_valid     (coef_valid),
        .coef_ready     (coef_ready),
        .coef_data      (coef_data),
        .coef_last      (coef_last),
        .smp_valid      (smp_valid),
        .smp_ready      (smp_ready),
        .smp_data       (smp_data),
        .fir_x_n        (fir_x_n),
        .fir_tvalid     (fir_tvalid),
        .fir_set_coeffs (fir_set_coeffs),
        .fir_y_n        (fir_y_n),
        .res_valid      (res_valid),
        .res_data       (res_data),
        .res_last       (res_last),
        .cfg_done       (cfg_done),
        .coef_err       (coef_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Filter stand-in: taps shift in while set_coeffs is high, y_n valid two cycles after tvalid.
    logic signed [13:0] mc [5];
    logic signed [13:0] md [5];
    logic signed [13:0] my_q;
    logic signed [13:0] my_sum;

    always_comb begin
        my_sum = '0;
        for (int k = 0; k < 5; k++) my_sum = my_sum + mc[k] * md[k];
    end

    always @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < 5; k++) begin
                mc[k] <= '0;
                md[k] <= '0;
            end
            my_q <= '0;
        end else begin
            if (fir_set_coeffs) begin
                mc[0] <= 14'($signed(fir_x_n));
                for (int k = 1; k < 5; k++) mc[k] <= mc[k-1];
            end
            if (fir_tvalid) begin
                md[0] <= 14'($signed(fir_x_n));
                for (int k = 1; k < 5; k++) md[k] <= md[k-1];
            end
            my_q <= my_sum;
        end
    end
    assign fir_y_n = my_q;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0]  prog_q [$];
    int          prog_t_q [$];
    logic [7:0]  tv_q [$];
    logic [13:0] res_q [$];
    logic        rl_q [$];
    int          cfg_cnt = 0;

    always @(negedge clk) begin
        if (fir_set_coeffs) begin
            prog_q.push_back(fir_x_n);
            prog_t_q.push_back(cyc);
        end
        if (fir_tvalid) tv_q.push_back(fir_x_n);
        if (res_valid) begin
            res_q.push_back(res_data);
            rl_q.push_back(res_last);
        end
        if (cfg_done) cfg_cnt++;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send_coef(input logic [5:0] d, input logic l);
        int n = 0;
        coef_valid = 1'b1;
        coef_data  = d;
        coef_last  = l;
        while (!coef_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("coef_hs_timeout", coef_ready, 1);
        @(negedge clk);
        coef_valid = 1'b0;
        coef_last  = 1'b0;
    endtask

    task automatic send_smp(input logic [7:0] d);
        int n = 0;
        smp_valid = 1'b1;
        smp_data  = d;
        while (!smp_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("smp_hs_timeout", smp_ready, 1);
        @(negedge clk);
        smp_valid = 1'b0;
    endtask

    task automatic wait_cfg();
        int n = 0;
        while (!cfg_done && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("cfg_timeout", cfg_done, 1);
        repeat (3) @(negedge clk);
    endtask

    // exp holds the five x_n values in drive order, first one in the top byte.
    task automatic check_prog(input int b, input logic [39:0] exp);
        chk("prog_len", prog_q.size() - b, 5);
        for (int i = 0; i < 5; i++) chk("prog_x", prog_q[b+i], exp[39-8*i -: 8]);
        chk("prog_contig", prog_t_q[b+4] - prog_t_q[b], 4);
    endtask

    logic        bad;
    logic [7:0]  rl;
    logic        hs_s, hs_c, sent;
    int          first, acc, n6;
    int          bp, bc, bt, br;

    initial begin
        reset = 1'b1; coef_valid = 1'b0; coef_data = '0; coef_last = 1'b0;
        smp_valid = 1'b0; smp_data = '0;

        // Reset values, then quiet INIT/IDLE with nothing offered.
        repeat (3) @(negedge clk);
        chk("rst_ctrl", {coef_ready, smp_ready, fir_tvalid, fir_set_coeffs,
                         res_valid, res_last, cfg_done, coef_err}, 8'h00);
        chk("rst_data", {fir_x_n, res_data}, 22'h0);
        reset = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bad = bad | coef_ready | smp_ready | fir_tvalid | fir_set_coeffs;
        end
        chk("idle_quiet", bad, 0);

        // INIT latency and tie-break, then load 1..5.
        reset = 1'b1;
        @(negedge clk);
        bp = prog_q.size(); bc = cfg_cnt;
        reset = 1'b0; coef_valid = 1'b1; coef_data = 6'd1; coef_last = 1'b0;
        smp_valid = 1'b1; smp_data = 8'h55; first = 0;
        for (int n = 1; n <= 20 && first == 0; n++) begin
            @(negedge clk);
            if (coef_ready) first = n;
        end
        chk("init_lat", first, 5);
        chk("tie_coef_wins", {coef_ready, smp_ready}, 2'b10);
        smp_valid = 1'b0;
        @(negedge clk);
        coef_valid = 1'b0;
        send_coef(6'd2, 1'b0); send_coef(6'd3, 1'b0);
        send_coef(6'd4, 1'b0); send_coef(6'd5, 1'b1);
        wait_cfg();
        check_prog(bp, 40'h05_04_03_02_01);
        chk("cfg_pulses", cfg_cnt - bc, 1);
        chk("coef_err_clean", coef_err, 0);

        // Short set: -3 only, then an over-long 7-beat set.
        bp = prog_q.size();
        send_coef(6'h3D, 1'b1);
        wait_cfg();
        check_prog(bp, 40'h00_00_00_00_FD);
        chk("coef_err_short", coef_err, 0);
        bp = prog_q.size();
        for (int i = 1; i <= 7; i++) send_coef(6'(i), i == 7);
        wait_cfg();
        check_prog(bp, 40'h05_04_03_02_01);
        chk("coef_err_set", coef_err, 1);
        send_coef(6'd1, 1'b0);
        for (int i = 0; i < 4; i++) send_coef(6'd0, i == 3);
        wait_cfg();
        chk("coef_err_sticky", coef_err, 1);

        // Three samples through an identity filter, flushed by the drain.
        bt = tv_q.size(); br = res_q.size();
        send_smp(8'd10); send_smp(8'hEC); send_smp(8'd30);
        repeat (15) @(negedge clk);
        chk("tv_count", tv_q.size() - bt, 8);
        for (int i = 0; i < 8; i++)
            chk("tv_x", tv_q[bt+i], (i == 0) ? 8'h0A : (i == 1) ? 8'hEC : (i == 2) ? 8'h1E : 8'h00);
        chk("res_count", res_q.size() - br, 8);
        rl = '0;
        for (int i = 0; i < 8; i++) begin
            chk("res_data", res_q[br+i],
                (i == 0) ? 14'h000A : (i == 1) ? 14'h3FEC : (i == 2) ? 14'h001E : 14'h0000);
            rl[i] = rl_q[br+i];
        end
        chk("res_last", rl, 8'h80);

        // Continuous stream with a coefficient load raised after sample 3.
        bt = tv_q.size(); br = res_q.size(); bp = prog_q.size();
        acc = 0; sent = 1'b0;
        smp_valid = 1'b1; smp_data = 8'd1;
        for (int c = 0; c < 300 && !cfg_done; c++) begin
            hs_s = smp_valid && smp_ready;
            hs_c = coef_valid && coef_ready;
            @(negedge clk);
            if (hs_s) begin
                acc++;
                smp_data = 8'(acc + 1);
            end
            if (hs_c) begin
                coef_valid = 1'b0;
                coef_last  = 1'b0;
            end
            if (acc == 3 && !sent) begin
                coef_valid = 1'b1; coef_data = 6'd1; coef_last = 1'b1; sent = 1'b1;
            end
        end
        smp_valid = 1'b0;
        chk("starve_cfg_seen", cfg_done, 1);
        chk("starve_accepted", acc, 16);
        repeat (12) @(negedge clk);
        chk("starve_tv_count", tv_q.size() - bt, 21);
        chk("starve_tv_first", tv_q[bt], 8'd1);
        chk("starve_tv_16th", tv_q[bt+15], 8'd16);
        bad = 1'b0;
        for (int i = 16; i < 21; i++) bad = bad | (tv_q[bt+i] != 8'h00);
        chk("starve_drain_zero", bad, 0);
        chk("starve_res_last", rl_q[br+20], 1);
        check_prog(bp, 40'h00_00_00_00_01);

        // Reset in the middle of programming.
        bc = cfg_cnt;
        send_coef(6'd7, 1'b0); send_coef(6'd7, 1'b0); send_coef(6'd7, 1'b1);
        n6 = 0;
        while (!fir_set_coeffs && n6 < 50) begin
            @(negedge clk);
            n6++;
        end
        if (n6 >= 50) chk("prog_start_timeout", fir_set_coeffs, 1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_ctrl", {coef_ready, smp_ready, fir_tvalid, fir_set_coeffs,
                             res_valid, res_last, cfg_done, coef_err}, 8'h00);
        chk("rst_mid_x", fir_x_n, 8'h00);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        chk("abort_no_cfg", cfg_cnt - bc, 0);
        chk("abort_err_clr", coef_err, 0);
        bp = prog_q.size();
        send_coef(6'd2, 1'b1);
        wait_cfg();
        check_prog(bp, 40'h00_00_00_00_02);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog cyc=%0d required=finish", cyc);
        $fatal(1, "watchdog");
    end

endmodule
